axi_read_arbiter_2x2: RTL and testbench

- Control-plane sequencer for the 2-master x 2-slave read path of the interconnect.
- Decodes each master's ARADDR against the programmed slave windows and arbitrates per slave with round-robin.
- Tracks each granted transaction from AR handshake through the final R beat.
- Drives the select and enable lines consumed by the AR/R datapath muxes. Carries no data itself.

---
 rtl/axi_read_arbiter_2x2.sv | 252 +++++++++++++++++++++++++
 tb/tb_axi_read_arbiter_2x2.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter_2x2.sv
// Purpose: 2x2 AXI read-path control sequencer: address decode, per-slave round-robin grant, burst tracking.
// Latency: grant 1 cycle after an eligible request; release on the edge carrying the RLAST handshake.
// Backpressure: a slave serves one burst at a time, so masters wait in IDLE/ADDR. An optional DATA watchdog
//               is enabled by defining the macro AXI_ARB_TIMEOUT_EN.
module axi_read_arbiter_2x2 #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 9
) (
  input  logic              G_clk,
  input  logic              G_reset,
  input  logic              M0_ARVALID,
  input  logic [ADDR_W-1:0] M0_ARADDR,
  input  logic              M1_ARVALID,
  input  logic [ADDR_W-1:0] M1_ARADDR,
  input  logic              M0_RREADY,
  input  logic              M1_RREADY,
  input  logic              S0_ARREADY,
  input  logic              S1_ARREADY,
  input  logic              S0_RVALID,
  input  logic              S1_RVALID,
  input  logic              S0_RLAST,
  input  logic              S1_RLAST,
  input  logic [ADDR_W-1:0] slave0_addr1,
  input  logic [ADDR_W-1:0] slave0_addr2,
  input  logic [ADDR_W-1:0] slave1_addr1,
  input  logic [ADDR_W-1:0] slave1_addr2,
  output logic              S0_active,
  output logic              S1_active,
  output logic              S0_sel,
  output logic              S1_sel,
  output logic              S0_ar_en,
  output logic              S1_ar_en,
  output logic              ARREADY_M0,
  output logic              ARREADY_M1,
  output logic              M0_route,
  output logic              M1_route,
  output logic              M0_busy,
  output logic              M1_busy,
  output logic              M0_unmapped,
  output logic              M1_unmapped,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // The watchdog counter must be able to hold the limit value.
  if ((2 ** CNT_W) <= TIMEOUT_CYC) begin : g_cnt_w_check
    $error("CNT_W too narrow for TIMEOUT_CYC");
  end

  // Per-index views of the flat port list: index m = master, index s = slave.
  logic [ADDR_W-1:0] araddr [2];
  logic [ADDR_W-1:0] win_lo [2];
  logic [ADDR_W-1:0] win_hi [2];
  logic [1:0]        arvalid;
  logic [1:0]        rready;
  logic [1:0]        s_arready;
  logic [1:0]        s_rvalid;
  logic [1:0]        s_rlast;

  assign araddr[0] = M0_ARADDR;
  assign araddr[1] = M1_ARADDR;
  assign win_lo[0] = slave0_addr1;
  assign win_hi[0] = slave0_addr2;
  assign win_lo[1] = slave1_addr1;
  assign win_hi[1] = slave1_addr2;
  assign arvalid   = {M1_ARVALID, M0_ARVALID};
  assign rready    = {M1_RREADY, M0_RREADY};
  assign s_arready = {S1_ARREADY, S0_ARREADY};
  assign s_rvalid  = {S1_RVALID, S0_RVALID};
  assign s_rlast   = {S1_RLAST, S0_RLAST};

  // State: per-slave FSM, owner and last grant; per-master busy flag and route.
  state_t     state_q [2];
  state_t     state_d [2];
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_grant_q, last_grant_d;
  logic [1:0] busy_q, busy_d;
  logic [1:0] route_q, route_d;

  logic [1:0] hit [2];   // hit[s][m]: master m address inside slave s window
  logic [1:0] req [2];   // req[s][m]: master m eligible to be granted slave s
  logic [1:0] mapped;
  logic [1:0] dest;
  logic [1:0] grant;
  logic [1:0] r_hs;
  logic [1:0] ar_en;
  logic [1:0] arready_m;

`ifdef AXI_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_q, timeout_d;
`endif

  // Window decode and request eligibility; slave 0 wins overlapping windows.
  always_comb begin
    mapped = '0;
    dest   = '0;
    for (int s = 0; s < 2; s++) begin
      hit[s] = '0;
      req[s] = '0;
    end
    for (int m = 0; m < 2; m++) begin
      for (int s = 0; s < 2; s++) begin
        hit[s][m] = (araddr[m] >= win_lo[s]) && (araddr[m] <= win_hi[s]);
      end
      mapped[m] = hit[0][m] | hit[1][m];
      dest[m]   = ~hit[0][m];
    end
    for (int s = 0; s < 2; s++) begin
      for (int m = 0; m < 2; m++) begin
        req[s][m] = arvalid[m] && mapped[m] && (dest[m] == 1'(s)) && !busy_q[m];
      end
    end
  end

  // Per-slave FSM next state, grant and busy/route bookkeeping, channel enables.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      state_d[s] = state_q[s];
    end
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    busy_d       = busy_q;
    route_d      = route_q;
    grant        = '0;
    r_hs         = '0;
    ar_en        = '0;
    arready_m    = '0;
`ifdef AXI_ARB_TIMEOUT_EN
    for (int s = 0; s < 2; s++) begin
      cnt_d[s] = cnt_q[s];
    end
    cnt_inc   = '0;
    timeout_d = 1'b0;
`endif
    for (int s = 0; s < 2; s++) begin
      r_hs[s]  = s_rvalid[s] && rready[sel_q[s]];
      // A tie goes to the master that did not win last time.
      grant[s] = (&req[s]) ? ~last_grant_q[s] : req[s][1];
      case (state_q[s])
        ST_IDLE: begin
          if (|req[s]) begin
            state_d[s]         = ST_ADDR;
            sel_d[s]           = grant[s];
            last_grant_d[s]    = grant[s];
            busy_d[grant[s]]   = 1'b1;
            route_d[grant[s]]  = 1'(s);
          end
        end
        ST_ADDR: begin
          ar_en[s]             = 1'b1;
          arready_m[sel_q[s]]  = s_arready[s];
          if (arvalid[sel_q[s]] && s_arready[s]) begin
            state_d[s] = ST_DATA;
`ifdef AXI_ARB_TIMEOUT_EN
            cnt_d[s]   = '0;
`endif
          end
        end
        ST_DATA: begin
          if (r_hs[s] && s_rlast[s]) begin
            state_d[s]        = ST_IDLE;
            busy_d[sel_q[s]]  = 1'b0;
          end
`ifdef AXI_ARB_TIMEOUT_EN
          else if (r_hs[s]) begin
            cnt_d[s] = '0;
          end else begin
            cnt_inc = cnt_q[s] + CNT_W'(1);
            if (cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
              state_d[s]        = ST_IDLE;
              busy_d[sel_q[s]]  = 1'b0;
              timeout_d         = 1'b1;
            end else begin
              cnt_d[s] = cnt_inc;
            end
          end
`endif
        end
        default: begin
          state_d[s] = ST_IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset; reset abandons any burst in flight.
  always_ff @(posedge G_clk) begin
    if (G_reset) begin
      for (int s = 0; s < 2; s++) begin
        state_q[s] <= ST_IDLE;
      end
      sel_q        <= '0;
      last_grant_q <= 2'b11;
      busy_q       <= '0;
      route_q      <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        state_q[s] <= state_d[s];
      end
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      route_q      <= route_d;
    end
  end

`ifdef AXI_ARB_TIMEOUT_EN
  // Watchdog counters and the single expiry pulse shared by both slaves.
  always_ff @(posedge G_clk) begin
    if (G_reset) begin
      for (int s = 0; s < 2; s++) begin
        cnt_q[s] <= '0;
      end
      timeout_q <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        cnt_q[s] <= cnt_d[s];
      end
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign S0_active   = (state_q[0] != ST_IDLE);
  assign S1_active   = (state_q[1] != ST_IDLE);
  assign S0_sel      = sel_q[0];
  assign S1_sel      = sel_q[1];
  assign S0_ar_en    = ar_en[0];
  assign S1_ar_en    = ar_en[1];
  assign ARREADY_M0  = arready_m[0];
  assign ARREADY_M1  = arready_m[1];
  assign M0_route    = route_q[0];
  assign M1_route    = route_q[1];
  assign M0_busy     = busy_q[0];
  assign M1_busy     = busy_q[1];
  assign M0_unmapped = arvalid[0] && !mapped[0];
  assign M1_unmapped = arvalid[1] && !mapped[1];

endmodule

// File: tb/tb_axi_read_arbiter_2x2.sv
// Bench for axi_read_arbiter_2x2: transaction-level ownership model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
// Inputs change 1 ns after the rising edge; the model compares on the falling edge.
`timescale 1ns/1ps
module tb_axi_read_arbiter_2x2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  arv, rrdy, s_ardy, s_rv, s_rl;
  logic [31:0] addr [2];
  logic [31:0] lo [2];
  logic [31:0] hi [2];

  logic S0_active, S1_active, S0_sel, S1_sel, S0_ar_en, S1_ar_en;
  logic ARREADY_M0, ARREADY_M1, M0_route, M1_route, M0_busy, M1_busy;
  logic M0_unmapped, M1_unmapped, timeout_err;

  always #5 clk = ~clk;

  axi_read_arbiter_2x2 #(.ADDR_W(32), .TIMEOUT_CYC(256), .CNT_W(9)) dut (
    .G_clk(clk), .G_reset(rst),
    .M0_ARVALID(arv[0]), .M0_ARADDR(addr[0]),
    .M1_ARVALID(arv[1]), .M1_ARADDR(addr[1]),
    .M0_RREADY(rrdy[0]), .M1_RREADY(rrdy[1]),
    .S0_ARREADY(s_ardy[0]), .S1_ARREADY(s_ardy[1]),
    .S0_RVALID(s_rv[0]), .S1_RVALID(s_rv[1]),
    .S0_RLAST(s_rl[0]), .S1_RLAST(s_rl[1]),
    .slave0_addr1(lo[0]), .slave0_addr2(hi[0]),
    .slave1_addr1(lo[1]), .slave1_addr2(hi[1]),
    .S0_active(S0_active), .S1_active(S1_active),
    .S0_sel(S0_sel), .S1_sel(S1_sel),
    .S0_ar_en(S0_ar_en), .S1_ar_en(S1_ar_en),
    .ARREADY_M0(ARREADY_M0), .ARREADY_M1(ARREADY_M1),
    .M0_route(M0_route), .M1_route(M1_route),
    .M0_busy(M0_busy), .M1_busy(M1_busy),
    .M0_unmapped(M0_unmapped), .M1_unmapped(M1_unmapped),
    .timeout_err(timeout_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Ownership model: each slave is free (-1) or owned by a master; an owned slave
  // has either not yet seen its AR handshake or is streaming R beats.
  int owner    [2] = '{-1, -1};
  bit ar_done  [2] = '{1'b0, 1'b0};
  int last_win [2] = '{1, 1};
  bit busy     [2] = '{1'b0, 1'b0};
  int route    [2] = '{0, 0};
  int n_owner [2];
  bit n_ar_done [2];
  int n_last_win [2];
  bit n_busy [2];
  int n_route [2];
  bit chk_en = 1'b0;

  function automatic int dest_of(input int m);
    if (addr[m] >= lo[0] && addr[m] <= hi[0]) return 0;
    if (addr[m] >= lo[1] && addr[m] <= hi[1]) return 1;
    return -1;
  endfunction

  // Compare DUT against the model, then work out the model's next cycle.
  always @(negedge clk) begin : cmp_p
    logic [1:0] e_act, e_aren, e_ardy, e_busy, e_unm;
    bit q0, q1;
    int g;
    if (chk_en) begin
      for (int s = 0; s < 2; s++) begin
        e_act[s]  = (owner[s] >= 0);
        e_aren[s] = (owner[s] >= 0) && !ar_done[s];
      end
      for (int m = 0; m < 2; m++) begin
        e_ardy[m] = 1'b0;
        for (int s = 0; s < 2; s++)
          if (owner[s] == m && !ar_done[s] && s_ardy[s]) e_ardy[m] = 1'b1;
        e_busy[m] = busy[m];
        e_unm[m]  = arv[m] && (dest_of(m) < 0);
      end
      chk("active",   {30'd0, S1_active, S0_active}, {30'd0, e_act});
      chk("ar_en",    {30'd0, S1_ar_en, S0_ar_en}, {30'd0, e_aren});
      chk("arready",  {30'd0, ARREADY_M1, ARREADY_M0}, {30'd0, e_ardy});
      chk("busy",     {30'd0, M1_busy, M0_busy}, {30'd0, e_busy});
      chk("unmapped", {30'd0, M1_unmapped, M0_unmapped}, {30'd0, e_unm});
      if (e_act[0]) chk("sel0", {31'd0, S0_sel}, owner[0]);
      if (e_act[1]) chk("sel1", {31'd0, S1_sel}, owner[1]);
      if (busy[0]) chk("route0", {31'd0, M0_route}, route[0]);
      if (busy[1]) chk("route1", {31'd0, M1_route}, route[1]);
`ifndef AXI_ARB_TIMEOUT_EN
      chk("timeout_err", {31'd0, timeout_err}, 32'd0);
`endif
      n_owner = owner; n_ar_done = ar_done; n_last_win = last_win;
      n_busy = busy; n_route = route;
      if (rst) begin
        n_owner = '{-1, -1}; n_ar_done = '{1'b0, 1'b0}; n_last_win = '{1, 1};
        n_busy = '{1'b0, 1'b0}; n_route = '{0, 0};
      end else begin
        for (int s = 0; s < 2; s++) begin
          if (owner[s] < 0) begin
            q0 = arv[0] && dest_of(0) == s && !busy[0];
            q1 = arv[1] && dest_of(1) == s && !busy[1];
            if (q0 && q1) g = (last_win[s] == 0) ? 1 : 0;
            else if (q0)  g = 0;
            else if (q1)  g = 1;
            else          g = -1;
            if (g >= 0) begin
              n_owner[s] = g; n_ar_done[s] = 1'b0; n_last_win[s] = g;
              n_busy[g] = 1'b1; n_route[g] = s;
            end
          end else if (!ar_done[s]) begin
            if (arv[owner[s]] && s_ardy[s]) n_ar_done[s] = 1'b1;
          end else if (s_rv[s] && rrdy[owner[s]] && s_rl[s]) begin
            n_owner[s] = -1;
            n_busy[owner[s]] = 1'b0;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (chk_en) begin
      owner = n_owner; ar_done = n_ar_done; last_win = n_last_win;
      busy = n_busy; route = n_route;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int exp_g [3];
    logic [31:0] tbl [8];
    exp_g = '{0, 1, 0};
    tbl = '{32'h0000_00FF, 32'h0000_0100, 32'h0000_0180, 32'h0000_01FF,
            32'h0000_0200, 32'h0000_02FF, 32'h0000_0300, 32'h0000_0140};
    rst = 1'b1;
    arv = '0; rrdy = 2'b11; s_ardy = '0; s_rv = '0; s_rl = '0;
    addr[0] = '0; addr[1] = '0;
    lo[0] = 32'h0000_0000; hi[0] = 32'h0FFF_FFFF;
    lo[1] = 32'h1000_0000; hi[1] = 32'h1FFF_FFFF;
    step(); step();
    chk("rst_active", {30'd0, S1_active, S0_active}, 32'd0);
    chk("rst_busy",   {30'd0, M1_busy, M0_busy}, 32'd0);
    chk("rst_arready",{30'd0, ARREADY_M1, ARREADY_M0}, 32'd0);
    chk("rst_sel_route", {28'd0, S1_sel, S0_sel, M1_route, M0_route}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    chk_en = 1'b1;
    rst = 1'b0;

    // Single 4-beat burst from M0 to S0.
    addr[0] = 32'h0000_0100; arv[0] = 1'b1; s_ardy[0] = 1'b1;
    step();
    chk("t1_active", {31'd0, S0_active}, 32'd1);
    chk("t1_arready", {31'd0, ARREADY_M0}, 32'd1);
    chk("t1_busy", {31'd0, M0_busy}, 32'd1);
    step();
    chk("t1_ar_en_off", {31'd0, S0_ar_en}, 32'd0);
    arv[0] = 1'b0; s_ardy[0] = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      s_rv[0] = 1'b1; s_rl[0] = (b == 4);
      step();
      if (b < 4) chk("t1_data_hold", {31'd0, S0_active}, 32'd1);
    end
    s_rv[0] = 1'b0; s_rl[0] = 1'b0;
    chk("t1_release", {30'd0, M0_busy, S0_active}, 32'd0);

    // Contention on S0 for three bursts: round-robin M0, M1, M0 with bubbles.
    do_reset();
    addr[0] = 32'h0000_0040; addr[1] = 32'h0000_0040; arv = 2'b11; s_ardy[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t2_active", {31'd0, S0_active}, 32'd1);
      chk("t2_sel", {31'd0, S0_sel}, exp_g[k]);
      step();
      arv[exp_g[k]] = 1'b0; s_rv[0] = 1'b1; s_rl[0] = 1'b1;
      step();
      s_rv[0] = 1'b0; s_rl[0] = 1'b0;
      chk("t2_bubble", {31'd0, S0_active}, 32'd0);
      arv[exp_g[k]] = 1'b1;
    end
    arv = '0; s_ardy = '0;
    do_reset();

    // Both slaves owned concurrently by different masters.
    addr[0] = 32'h0000_0000; addr[1] = 32'h1000_0000; arv = 2'b11; s_ardy = 2'b11;
    step();
    chk("t3_active", {30'd0, S1_active, S0_active}, 32'd3);
    chk("t3_sel", {30'd0, S1_sel, S0_sel}, 32'd2);
    chk("t3_route", {30'd0, M1_route, M0_route}, 32'd2);
    step();
    arv = '0; s_ardy = '0; s_rv = 2'b11; s_rl = 2'b11;
    step();
    s_rv = '0; s_rl = '0;
    chk("t3_release", {28'd0, S1_active, S0_active, M1_busy, M0_busy}, 32'd0);

    // Unmapped request from M1.
    addr[1] = 32'h8000_0000; arv[1] = 1'b1; s_ardy = 2'b11;
    step();
    chk("t4_unmapped", {31'd0, M1_unmapped}, 32'd1);
    step();
    chk("t4_no_grant", {29'd0, S1_active, S0_active, M1_busy}, 32'd0);
    arv = '0; s_ardy = '0;

    // Reset in the middle of an 8-beat burst, then a tie must go to M0.
    addr[0] = 32'h0000_0010; arv[0] = 1'b1; s_ardy[0] = 1'b1;
    step(); step();
    arv[0] = 1'b0; s_ardy[0] = 1'b0; s_rv[0] = 1'b1;
    step(); step();
    rst = 1'b1; s_rv[0] = 1'b0;
    step();
    chk("t5_reset", {30'd0, M0_busy, S0_active}, 32'd0);
    rst = 1'b0; addr[0] = 32'h0000_0040; addr[1] = 32'h0000_0040; arv = 2'b11;
    step();
    chk("t5_tie_m0", {30'd0, S0_active, S0_sel}, 32'd2);
    arv = '0;
    do_reset();

    // Randomized traffic over overlapping windows with boundary addresses.
    lo[0] = 32'h0000_0100; hi[0] = 32'h0000_01FF;
    lo[1] = 32'h0000_0180; hi[1] = 32'h0000_02FF;
    for (int c = 0; c < 4000; c++) begin
      arv    = 2'($urandom);
      rrdy   = 2'($urandom | $urandom);
      s_ardy = 2'($urandom);
      s_rv   = 2'($urandom);
      s_rl   = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      for (int m = 0; m < 2; m++)
        addr[m] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 32'h3FF))
                                              : tbl[$urandom_range(0, 7)];
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; arv = '0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
